spi_master_param: RTL and testbench
===================================

# spi_master_param

Parametrised SPI master that supersedes the fixed 8-bit, single-slave SPI main block. It supports all four SPI modes per transfer, configurable word width, an SCLK divider, multiple chip selects and MSB/LSB-first ordering. A valid/ready handshake on the transmit side and a one-cycle result strobe on the receive side connect it to a local controller. It sits between that controller and the board-level SPI pins.

## Interface
- DATA_W, 8: bits per word, ≥2.
- CLK_DIV, 4: i_clk cycles per SCLK half-period, ≥1.
- NUM_CS, 2: number of chip-select outputs, ≥1.
- CS_W, 1: width of i_cs_sel; must satisfy 2^CS_W ≥ NUM_CS.
- i_clk  in  1  sole clock; all logic on posedge.
- i_rst  in  1  synchronous, active-high reset.
- i_mode  in  2  SPI mode {CPOL,CPHA}; sampled only on accept.
- i_lsb_first  in  1  1 = LSB first; sampled on accept.
- i_cs_sel  in  CS_W  target slave index; sampled on accept.
- i_tx_byte  in  DATA_W  word to send; sampled on accept.
- i_tx_valid  in  1  request; accept = i_tx_valid & o_tx_ready at posedge.
- o_tx_ready  out  1  block can accept a word.
- o_rx_byte  out  DATA_W  last received word; holds until next o_rx_valid.
- o_rx_valid  out  1  one-cycle strobe, o_rx_byte updated this cycle.
- o_busy  out  1  high in any state except IDLE.
- o_sclk, o_mosi  out  1 each  SPI clock / data out.
- i_miso  in  1  SPI data in; sampled directly (external sync is the integrator's job).
- o_cs_n  out  NUM_CS  active-low chip selects, one-hot-low when asserted.

## Operation
- All outputs registered. Reset values: o_sclk 0, o_mosi 0, o_cs_n all 1, o_rx_byte 0, o_rx_valid 0, o_busy 0, o_tx_ready 0 (rises first cycle after i_rst falls). Latched mode resets to 0.
- States: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE: o_tx_ready 1; o_sclk holds CPOL of last latched mode. Accept latches mode, order, cs_sel, tx word; o_tx_ready drops next cycle.
- SETUP (CLK_DIV cycles): selected o_cs_n low, o_sclk = latched CPOL; if CPHA=0, o_mosi = first bit.
- SHIFT (2·DATA_W half-periods): o_sclk toggles at end of each half-period. CPHA=0: sample i_miso on leading edges, drive next bit on trailing edges. CPHA=1: drive bit on leading edges, sample on trailing edges. Bit order per latched i_lsb_first, for both MOSI and received word assembly.
- HOLD (CLK_DIV cycles): o_sclk at CPOL, o_cs_n still low. On exit all o_cs_n high, o_rx_byte loaded, o_rx_valid pulses, o_tx_ready 1.
- i_cs_sel ≥ NUM_CS: transfer runs normally, no o_cs_n asserted, o_rx_valid still pulses.
- Input changes while o_busy are ignored; i_tx_valid while not ready is not accepted and not queued.
- i_rst mid-transfer: next cycle all reset values, transfer discarded, no o_rx_valid.

## Timing
- Accept at edge 0 → SETUP cycles 1..CLK_DIV → SHIFT through CLK_DIV·(2·DATA_W+1) → HOLD through CLK_DIV·(2·DATA_W+2) → o_rx_valid, o_tx_ready, o_cs_n high in cycle CLK_DIV·(2·DATA_W+2)+1.
- DATA_W=8, CLK_DIV=2: accept-to-o_rx_valid 37 cycles. Back-to-back: next accept that same cycle, CS high for ≥1 cycle between words.
- SCLK frequency = f(i_clk)/(2·CLK_DIV); CLK_DIV=1 gives f/2.

## Configuration
- SPI_MASTER_BURST_EN defined: o_tx_ready also high in the final cycle of SHIFT. Accept there with i_cs_sel equal to the latched value skips HOLD/SETUP. CS stays low, SHIFT restarts next cycle, and o_rx_valid for the finished word pulses that same cycle. Mode/order stay as latched (new i_mode, i_lsb_first ignored). Differing i_cs_sel is not accepted there (o_tx_ready forced low that cycle).
- Not defined: o_tx_ready only in IDLE; every word framed by SETUP/HOLD.

## Test plan
- Mode 0, MSB first, DATA_W=8, CLK_DIV=2, tx 0xA5, slave loopback returning 0x3C → MOSI 1,0,1,0,0,1,0,1 on SCLK rising samples; o_rx_byte 0x3C, o_rx_valid at cycle 37, o_cs_n[0] low cycles 1–36.
- Modes 1/2/3 with tx 0x81, miso pattern 0xC3 → idle SCLK = CPOL, data changes on the correct edge per CPHA, o_rx_byte 0xC3 each.
- i_lsb_first=1, tx 0x01, miso 0x80 → first MOSI bit 1, o_rx_byte 0x01.
- i_cs_sel=1 then 3 with NUM_CS=2 → o_cs_n=2'b01 during first; second keeps 2'b11 but o_rx_valid still pulses.
- i_rst asserted at cycle 10 of a transfer → next cycle o_cs_n all 1, o_sclk 0, o_busy 0, no o_rx_valid; o_tx_ready 1 one cycle after release.
- With SPI_MASTER_BURST_EN, two words 0x12, 0x34 held valid → CS low continuously for 2×16 half-periods plus SETUP/HOLD; two o_rx_valid pulses 32 cycles apart (CLK_DIV=2).

Source files
------------

// File: rtl/spi_master_param_if.sv
// rtl/spi_master_param_if.sv - controller handshake and SPI pin bundle for spi_master_param
interface spi_master_param_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 2,
   parameter int CS_W   = 1
);
   logic [1:0]        i_mode;
   logic              i_lsb_first;
   logic [CS_W-1:0]   i_cs_sel;
   logic [DATA_W-1:0] i_tx_byte;
   logic              i_tx_valid;
   logic              o_tx_ready;
   logic [DATA_W-1:0] o_rx_byte;
   logic              o_rx_valid;
   logic              o_busy;
   logic              o_sclk;
   logic              o_mosi;
   logic              i_miso;
   logic [NUM_CS-1:0] o_cs_n;

   modport master (
      input  i_mode, i_lsb_first, i_cs_sel, i_tx_byte, i_tx_valid, i_miso,
      output o_tx_ready, o_rx_byte, o_rx_valid, o_busy, o_sclk, o_mosi, o_cs_n
   );

   modport slave (
      output i_mode, i_lsb_first, i_cs_sel, i_tx_byte, i_tx_valid, i_miso,
      input  o_tx_ready, o_rx_byte, o_rx_valid, o_busy, o_sclk, o_mosi, o_cs_n
   );
endinterface

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master, four modes, MSB/LSB order, multi-CS
// Optional back-to-back word bursting with CS held low: define SPI_MASTER_BURST_EN.
module spi_master_param #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4,
   parameter int NUM_CS  = 2,
   parameter int CS_W    = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   spi_master_param_if.master bus
);
   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_W);
   localparam int HALF_W = BIT_W + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(2 * DATA_W - 1);
   localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
   state_t state, state_d;

   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [HALF_W-1:0] half, half_d;
   logic [BIT_W-1:0]  bit_i;
   logic [1:0]        mode_q;
   logic              lsb_q;
   logic [DATA_W-1:0] tx_q, rx_sh, rx_next;
   logic              sclk_q, mosi_q, rx_valid_q, busy_q, ready_q, ready_d, tx_ready;
   logic [NUM_CS-1:0] cs_n_q;
   logic [DATA_W-1:0] rx_byte_q;
   logic              accept, cnt_done, edge_now, lead, burst_go;

   function automatic logic [BIT_W-1:0] bit_idx(input logic [BIT_W-1:0] i, input logic lsb);
      return lsb ? i : BIT_MAX - i;
   endfunction

   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] v;
      v = '1;
      for (int k = 0; k < NUM_CS; k++)
         if (int'(sel) == k) v[k] = 1'b0;
      return v;
   endfunction

`ifdef SPI_MASTER_BURST_EN
   logic [CS_W-1:0] cs_q;
   // A burst may only continue to the slave already selected.
   assign tx_ready = ready_q && !((state == SHIFT) && (bus.i_cs_sel != cs_q));
`else
   assign tx_ready = ready_q;
`endif

   always_comb begin
      state_d  = state;
      cnt_d    = '0;
      half_d   = '0;
      burst_go = 1'b0;
      accept   = bus.i_tx_valid && tx_ready;
      cnt_done = (cnt == CNT_MAX);
      edge_now = (state == SHIFT) && cnt_done;
      lead     = !half[0];
      bit_i    = half[HALF_W-1:1];
      rx_next  = rx_sh;
      // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
      if (edge_now && (lead != mode_q[0]))
         rx_next[bit_idx(bit_i, lsb_q)] = bus.i_miso;
      case (state)
         IDLE: if (accept) state_d = SETUP;
         SETUP: begin
            cnt_d = cnt_done ? '0 : cnt + 1'b1;
            if (cnt_done) state_d = SHIFT;
         end
         SHIFT: begin
            cnt_d  = cnt_done ? '0 : cnt + 1'b1;
            half_d = cnt_done ? half + 1'b1 : half;
            if (cnt_done && (half == HALF_MAX)) begin
               half_d = '0;
`ifdef SPI_MASTER_BURST_EN
               burst_go = accept;
`endif
               state_d = burst_go ? SHIFT : HOLD;
            end
         end
         HOLD: begin
            cnt_d = cnt_done ? '0 : cnt + 1'b1;
            if (cnt_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
`ifdef SPI_MASTER_BURST_EN
      if ((state_d == SHIFT) && (cnt_d == CNT_MAX) && (half_d == HALF_MAX))
         ready_d = 1'b1;
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         cnt        <= '0;
         half       <= '0;
         mode_q     <= 2'b00;
         lsb_q      <= 1'b0;
         tx_q       <= '0;
         rx_sh      <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
         cs_q       <= '0;
`endif
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         half       <= half_d;
         busy_q     <= (state_d != IDLE);
         ready_q    <= ready_d;
         rx_valid_q <= 1'b0;
         rx_sh      <= rx_next;
         if ((state == IDLE) && accept) begin
            mode_q <= bus.i_mode;
            lsb_q  <= bus.i_lsb_first;
            tx_q   <= bus.i_tx_byte;
            cs_n_q <= cs_decode(bus.i_cs_sel);
            sclk_q <= bus.i_mode[1];
            if (!bus.i_mode[0])
               mosi_q <= bus.i_tx_byte[bit_idx('0, bus.i_lsb_first)];
`ifdef SPI_MASTER_BURST_EN
            cs_q <= bus.i_cs_sel;
`endif
         end
         if (edge_now) begin
            sclk_q <= !sclk_q;
            if (lead == mode_q[0]) begin
               if (mode_q[0])
                  mosi_q <= tx_q[bit_idx(bit_i, lsb_q)];
               else if (bit_i != BIT_MAX)
                  mosi_q <= tx_q[bit_idx(bit_i + 1'b1, lsb_q)];
            end
         end
         if (burst_go) begin
            tx_q       <= bus.i_tx_byte;
            rx_byte_q  <= rx_next;
            rx_valid_q <= 1'b1;
            if (!mode_q[0])
               mosi_q <= bus.i_tx_byte[bit_idx('0, lsb_q)];
         end
         if ((state == HOLD) && cnt_done) begin
            cs_n_q     <= '1;
            rx_byte_q  <= rx_sh;
            rx_valid_q <= 1'b1;
         end
      end
   end

   assign bus.o_tx_ready = tx_ready;
   assign bus.o_rx_byte  = rx_byte_q;
   assign bus.o_rx_valid = rx_valid_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_sclk     = sclk_q;
   assign bus.o_mosi     = mosi_q;
   assign bus.o_cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - self-checking bench for spi_master_param with a behavioural SPI slave
module tb_spi_master_param;
   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int NUM_CS  = 2;
   localparam int CS_W    = 2;
   localparam int RX_LAT  = CLK_DIV * (2 * DATA_W + 2) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   spi_master_param_if #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .CS_W(CS_W)) bus ();

   spi_master_param #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS), .CS_W(CS_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic cpol_t, cpha_t, sclk_prev, mosi_prev;
   bit   slave_q[$];
   logic seen_q[$];
   int   edge_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave reacts to SCLK edges seen one step after the clock edge that made them.
   task automatic slave_step();
      logic is_lead;
      if (bus.o_sclk !== sclk_prev) begin
         is_lead = (sclk_prev === cpol_t);
         if (is_lead != cpha_t) begin
            seen_q.push_back(bus.o_mosi);
            if (bus.o_mosi !== mosi_prev) edge_err++;
         end else if (slave_q.size() > 0) begin
            bus.i_miso = slave_q.pop_front();
         end
      end
      sclk_prev = bus.o_sclk;
      mosi_prev = bus.o_mosi;
   endtask

   task automatic slave_load(input logic [DATA_W-1:0] pat);
      for (int i = DATA_W - 1; i >= 0; i--) slave_q.push_back(pat[i]);
   endtask

   task automatic slave_arm(input logic [1:0] mode);
      cpol_t    = mode[1];
      cpha_t    = mode[0];
      sclk_prev = bus.o_sclk;
      mosi_prev = bus.o_mosi;
      edge_err  = 0;
      if (!cpha_t && slave_q.size() > 0) bus.i_miso = slave_q.pop_front();
   endtask

   task automatic start(input logic [1:0] mode, input logic lsb, input int cs, input logic [DATA_W-1:0] tx);
      int n;
      n = 0;
      while (bus.o_tx_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_before_accept", bus.o_tx_ready, 1);
      bus.i_mode      = mode;
      bus.i_lsb_first = lsb;
      bus.i_cs_sel    = CS_W'(cs);
      bus.i_tx_byte   = tx;
      bus.i_tx_valid  = 1'b1;
      @(posedge clk); #1;
      bus.i_tx_valid  = 1'b0;
   endtask

   task automatic run_xfer(input logic [1:0] mode, input logic lsb, input int cs,
                           input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] pat);
      logic [DATA_W-1:0] exp_seq, exp_rx, seen_w;
      logic [NUM_CS-1:0] exp_cs;
      int cs_bad, rxv_cyc, extra;
      for (int i = 0; i < DATA_W; i++) begin
         exp_seq[DATA_W-1-i]               = lsb ? tx[i] : tx[DATA_W-1-i];
         exp_rx[lsb ? i : DATA_W-1-i]      = pat[DATA_W-1-i];
      end
      exp_cs = '1;
      if (cs < NUM_CS) exp_cs[cs] = 1'b0;
      seen_q.delete();
      slave_q.delete();
      slave_load(pat);
      start(mode, lsb, cs, tx);
      slave_arm(mode);
      check("busy_cycle1", bus.o_busy, 1);
      check("ready_cycle1", bus.o_tx_ready, 0);
      cs_bad = 0; rxv_cyc = -1; extra = 0;
      for (int c = 1; c <= RX_LAT + 4; c++) begin
         if (c > 1) slave_step();
         if (c < RX_LAT && bus.o_cs_n !== exp_cs) cs_bad++;
         if (c == 10) begin
            bus.i_tx_valid = 1'b1;
            bus.i_tx_byte  = DATA_W'($urandom);
            bus.i_mode     = 2'($urandom);
         end
         if (c == 13) bus.i_tx_valid = 1'b0;
         if (bus.o_rx_valid === 1'b1) begin
            if (rxv_cyc < 0) rxv_cyc = c; else extra++;
         end
         if (c == RX_LAT) begin
            check("cs_released", bus.o_cs_n, {NUM_CS{1'b1}});
            check("ready_at_done", bus.o_tx_ready, 1);
            check("busy_at_done", bus.o_busy, 0);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < seen_q.size() && i < DATA_W; i++) seen_w[DATA_W-1-i] = seen_q[i];
      check("rx_valid_cycle", rxv_cyc, RX_LAT);
      check("rx_valid_single", extra, 0);
      check("rx_byte", bus.o_rx_byte, exp_rx);
      check("mosi_bit_count", seen_q.size(), DATA_W);
      check("mosi_bits", seen_w, exp_seq);
      check("mosi_first_bit", seen_w[DATA_W-1], exp_seq[DATA_W-1]);
      check("mosi_stable_at_sample", edge_err, 0);
      check("cs_during_xfer", cs_bad, 0);
      check("idle_sclk_cpol", bus.o_sclk, mode[1]);
   endtask

   initial begin
      int rxv;
      bus.i_mode = 2'b00; bus.i_lsb_first = 1'b0; bus.i_cs_sel = '0;
      bus.i_tx_byte = '0; bus.i_tx_valid = 1'b0; bus.i_miso = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk", bus.o_sclk, 0);
      check("rst_mosi", bus.o_mosi, 0);
      check("rst_cs_n", bus.o_cs_n, {NUM_CS{1'b1}});
      check("rst_rx_byte", bus.o_rx_byte, 0);
      check("rst_rx_valid", bus.o_rx_valid, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_ready", bus.o_tx_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", bus.o_tx_ready, 1);

      run_xfer(2'd0, 1'b0, 0, 8'hA5, 8'h3C);
      run_xfer(2'd1, 1'b0, 0, 8'h81, 8'hC3);
      run_xfer(2'd2, 1'b0, 0, 8'h81, 8'hC3);
      run_xfer(2'd3, 1'b0, 0, 8'h81, 8'hC3);
      run_xfer(2'd0, 1'b1, 0, 8'h01, 8'h80);
      run_xfer(2'd0, 1'b0, 1, 8'h5A, 8'h96);
      run_xfer(2'd2, 1'b0, 3, 8'h77, 8'h0F);
      for (int k = 0; k < 6; k++)
         run_xfer(2'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  DATA_W'($urandom), DATA_W'($urandom));

      // Reset in the middle of a CPOL=1 transfer.
      start(2'd3, 1'b0, 0, 8'hF0);
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_cs_n", bus.o_cs_n, {NUM_CS{1'b1}});
      check("midrst_sclk", bus.o_sclk, 0);
      check("midrst_busy", bus.o_busy, 0);
      check("midrst_rx_valid", bus.o_rx_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_ready_after", bus.o_tx_ready, 1);
      rxv = 0;
      for (int c = 0; c < 60; c++) begin
         if (bus.o_rx_valid === 1'b1) rxv++;
         @(posedge clk); #1;
      end
      check("midrst_no_rx_valid", rxv, 0);
      run_xfer(2'd1, 1'b1, 1, 8'h3E, 8'hB4);

`ifdef SPI_MASTER_BURST_EN
      begin
         logic [DATA_W-1:0] rx_got[$];
         logic [2*DATA_W-1:0] seen2;
         int cs_hi, first_rx, last_rx;
         seen_q.delete(); slave_q.delete();
         slave_load(8'h5A); slave_load(8'hE1);
         start(2'd0, 1'b0, 0, 8'h12);
         bus.i_tx_byte = 8'h34; bus.i_tx_valid = 1'b1;
         slave_arm(2'd0);
         cs_hi = 0; first_rx = -1; last_rx = -1;
         for (int c = 1; c < 120; c++) begin
            if (c > 1) slave_step();
            if (bus.o_rx_valid === 1'b1) begin
               rx_got.push_back(bus.o_rx_byte);
               if (first_rx < 0) first_rx = c;
               last_rx = c;
            end
            if (last_rx < 0 || c < last_rx) if (bus.o_cs_n[0] !== 1'b0 && (first_rx < 0 || rx_got.size() < 2)) cs_hi++;
            if (bus.i_tx_valid && bus.o_tx_ready === 1'b1) begin
               @(posedge clk); #1;
               bus.i_tx_valid = 1'b0;
               slave_step();
               continue;
            end
            @(posedge clk); #1;
         end
         for (int i = 0; i < seen_q.size() && i < 2 * DATA_W; i++) seen2[2*DATA_W-1-i] = seen_q[i];
         check("burst_rx_count", rx_got.size(), 2);
         check("burst_rx0", (rx_got.size() > 0) ? rx_got[0] : 8'hxx, 8'h5A);
         check("burst_rx1", (rx_got.size() > 1) ? rx_got[1] : 8'hxx, 8'hE1);
         check("burst_mosi", seen2, 16'h1234);
         check("burst_cs_low", cs_hi, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
